router_register_gen: RTL

- Parametrised next-generation router input register stage, between the router input port and the per-destination output FIFOs.
- Self-sequences each packet from its header: header byte, then LEN payload bytes, then one parity byte.
- Contains:
  - destination decode with drop of invalid addresses;
  - running XOR parity;
  - length checking;
  - a HOLD_DEPTH-entry hold buffer that absorbs downstream FIFO-full stalls and back-pressures upstream with busy.

---
 rtl/router_pkg.sv | 22 ++
 rtl/router_register_gen_if.sv | 43 ++++
 rtl/router_hold_buf.sv | 53 +++++
 rtl/router_register_gen.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/router_pkg.sv
// Shared types and defaults for the router input register stage.
//   state_t        : packet sequencer states
//   DEF_*          : default bus/port/buffer sizing
//   HDR_DEST_LSB   : header layout is {len, dest}; dest starts at bit 0 and len sits directly above it
package router_pkg;

  localparam int unsigned DEF_DW         = 8;
  localparam int unsigned DEF_ADDR_W     = 2;
  localparam int unsigned DEF_NUM_PORTS  = 3;
  localparam int unsigned DEF_HOLD_DEPTH = 4;

  localparam int unsigned HDR_DEST_LSB = 0;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    PAYLOAD = 3'd1,
    PARITY  = 3'd2,
    CHECK   = 3'd3,
    DROP    = 3'd4
  } state_t;

endpackage

// File: rtl/router_register_gen_if.sv
// Byte-stream interface between upstream port, register stage and destination FIFO.
//   master : upstream/FIFO side (drives pkt_vld, din, fifo_full)
//   slave  : register stage (drives busy, dout, dout_vld, dest, status flags)
// Optional err_cnt signal present when ROUTER_ERR_CNT_EN is defined.
interface router_register_gen_if #(
  parameter int unsigned DW     = router_pkg::DEF_DW,
  parameter int unsigned ADDR_W = router_pkg::DEF_ADDR_W
) ();

  logic              pkt_vld;
  logic [DW-1:0]     din;
  logic              busy;
  logic              fifo_full;
  logic [DW-1:0]     dout;
  logic              dout_vld;
  logic [ADDR_W-1:0] dest;
  logic              parity_done;
  logic              low_pkt_valid;
  logic              err;
  logic              pkt_drop;
`ifdef ROUTER_ERR_CNT_EN
  logic [7:0]        err_cnt;

  modport master (
    output pkt_vld, din, fifo_full,
    input  busy, dout, dout_vld, dest, parity_done, low_pkt_valid, err, pkt_drop, err_cnt
  );
  modport slave (
    input  pkt_vld, din, fifo_full,
    output busy, dout, dout_vld, dest, parity_done, low_pkt_valid, err, pkt_drop, err_cnt
  );
`else
  modport master (
    output pkt_vld, din, fifo_full,
    input  busy, dout, dout_vld, dest, parity_done, low_pkt_valid, err, pkt_drop
  );
  modport slave (
    input  pkt_vld, din, fifo_full,
    output busy, dout, dout_vld, dest, parity_done, low_pkt_valid, err, pkt_drop
  );
`endif

endinterface

// File: rtl/router_hold_buf.sv
// Synchronous FIFO that absorbs destination stalls.
//   clk, rstn      : clock, synchronous active-low flush
//   push, wdata    : write (ignored when full)
//   pop, rdata     : read; rdata is the current head (valid when !empty)
//   full, empty    : occupancy flags
//   count          : number of stored entries, 0..DEPTH
module router_hold_buf #(
  parameter int unsigned DW    = 8,
  parameter int unsigned DEPTH = 4,
  localparam int unsigned PTR_W = $clog2(DEPTH),
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             push,
  input  logic [DW-1:0]    wdata,
  input  logic             pop,
  output logic [DW-1:0]    rdata,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  logic [DW-1:0]    mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr];

  // Storage array carries no reset; occupancy is tracked by the pointers.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

endmodule

// File: rtl/router_register_gen.sv
// Router input register stage: sequences header / LEN payload / parity bytes,
// drops invalid destinations, checks XOR parity and length, and buffers bytes
// in a hold FIFO while the destination FIFO is full.
//   clk, rstn : clock, synchronous active-low reset
//   bus       : router_register_gen_if.slave (pkt_vld, din, busy, fifo_full,
//               dout, dout_vld, dest, parity_done, low_pkt_valid, err, pkt_drop)
// Optional: define ROUTER_ERR_CNT_EN to add bus.err_cnt, a saturating count
// of failed checks plus dropped packets.
module router_register_gen
  import router_pkg::*;
#(
  parameter int unsigned DW         = DEF_DW,
  parameter int unsigned ADDR_W     = DEF_ADDR_W,
  parameter int unsigned NUM_PORTS  = DEF_NUM_PORTS,
  parameter int unsigned HOLD_DEPTH = DEF_HOLD_DEPTH
) (
  input  logic                  clk,
  input  logic                  rstn,
  router_register_gen_if.slave  bus
);

  localparam int unsigned LEN_W = DW - ADDR_W;
  localparam int unsigned CNT_W = $clog2(HOLD_DEPTH) + 1;

  state_t            state;
  logic [LEN_W-1:0]  len_q;
  logic [LEN_W-1:0]  cnt_q;
  logic [DW-1:0]     acc_q;
  logic [DW-1:0]     par_q;
  logic              len_err_q;
  logic [DW-1:0]     dout_q;
  logic              dout_vld_q;
  logic [ADDR_W-1:0] dest_q;
  logic              parity_done_q;
  logic              err_q;
  logic              pkt_drop_q;

  logic [DW-1:0]     buf_rdata;
  logic              buf_full;
  logic              buf_empty;
  logic [CNT_W-1:0]  buf_count;

  logic [ADDR_W-1:0] hdr_dest;
  logic [LEN_W-1:0]  hdr_len;
  logic              hdr_ok;
  logic              busy_c;
  logic              accept_c;
  logic              push_c;
  logic              bypass_c;
  logic              pop_c;
  logic              chk_err_c;

  assign hdr_dest  = bus.din[HDR_DEST_LSB +: ADDR_W];
  assign hdr_len   = bus.din[HDR_DEST_LSB + ADDR_W +: LEN_W];
  assign hdr_ok    = (32'(hdr_dest) < NUM_PORTS);

  // Busy follows the registered occupancy, so a pop in the same cycle does not lift it.
  assign busy_c    = (buf_count == CNT_W'(HOLD_DEPTH));
  assign accept_c  = !busy_c && (state != CHECK) &&
                     (bus.pkt_vld || state == PAYLOAD || state == PARITY || state == DROP);
  assign push_c    = accept_c && ((state == IDLE && hdr_ok) || state == PAYLOAD || state == PARITY);
  // An empty buffer with a free FIFO forwards the accepted byte straight to dout.
  assign bypass_c  = push_c && buf_empty && !bus.fifo_full;
  assign pop_c     = !buf_empty && !bus.fifo_full;
  assign chk_err_c = (acc_q != par_q) || len_err_q;

  router_hold_buf #(
    .DW    (DW),
    .DEPTH (HOLD_DEPTH)
  ) u_hold_buf (
    .clk   (clk),
    .rstn  (rstn),
    .push  (push_c && !bypass_c && !buf_full),
    .wdata (bus.din),
    .pop   (pop_c),
    .rdata (buf_rdata),
    .full  (buf_full),
    .empty (buf_empty),
    .count (buf_count)
  );

  // Packet sequencer and registered outputs.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state         <= IDLE;
      len_q         <= '0;
      cnt_q         <= '0;
      acc_q         <= '0;
      par_q         <= '0;
      len_err_q     <= 1'b0;
      dout_q        <= '0;
      dout_vld_q    <= 1'b0;
      dest_q        <= '0;
      parity_done_q <= 1'b0;
      err_q         <= 1'b0;
      pkt_drop_q    <= 1'b0;
    end else begin
      pkt_drop_q <= 1'b0;
      dout_vld_q <= 1'b0;
      if (bypass_c) begin
        dout_q     <= bus.din;
        dout_vld_q <= 1'b1;
      end else if (pop_c) begin
        dout_q     <= buf_rdata;
        dout_vld_q <= 1'b1;
      end

      case (state)
        IDLE: begin
          if (accept_c) begin
            if (hdr_ok) begin
              dest_q        <= hdr_dest;
              len_q         <= hdr_len;
              acc_q         <= bus.din;
              cnt_q         <= '0;
              parity_done_q <= 1'b0;
              state         <= (hdr_len == '0) ? PARITY : PAYLOAD;
            end else begin
              state <= DROP;
            end
          end
        end
        PAYLOAD: begin
          if (accept_c) begin
            cnt_q <= cnt_q + LEN_W'(1);
            if (bus.pkt_vld) begin
              acc_q <= acc_q ^ bus.din;
              if (cnt_q + LEN_W'(1) == len_q) state <= PARITY;
            end else begin
              // Packet ended early: this byte is its parity byte.
              par_q     <= bus.din;
              len_err_q <= 1'b1;
              state     <= CHECK;
            end
          end
        end
        PARITY: begin
          if (accept_c) begin
            par_q <= bus.din;
            if (bus.pkt_vld) len_err_q <= 1'b1;
            state <= CHECK;
          end
        end
        CHECK: begin
          err_q         <= chk_err_c;
          parity_done_q <= 1'b1;
          cnt_q         <= '0;
          len_err_q     <= 1'b0;
          state         <= IDLE;
        end
        DROP: begin
          if (accept_c && !bus.pkt_vld) begin
            pkt_drop_q <= 1'b1;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef ROUTER_ERR_CNT_EN
  logic [7:0] err_cnt_q;
  logic       err_evt_c;

  assign err_evt_c = (state == CHECK && chk_err_c) ||
                     (state == DROP && accept_c && !bus.pkt_vld);

  // Saturating error/drop event counter.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      err_cnt_q <= '0;
    end else if (err_evt_c && err_cnt_q != 8'hFF) begin
      err_cnt_q <= err_cnt_q + 8'd1;
    end
  end

  assign bus.err_cnt = err_cnt_q;
`endif

  assign bus.busy          = busy_c;
  assign bus.dout          = dout_q;
  assign bus.dout_vld      = dout_vld_q;
  assign bus.dest          = dest_q;
  assign bus.parity_done   = parity_done_q;
  assign bus.err           = err_q;
  assign bus.pkt_drop      = pkt_drop_q;
  assign bus.low_pkt_valid = (state == PAYLOAD || state == PARITY) && !bus.pkt_vld;

endmodule
